// File: rtl/seq_run_ctrl_if.sv
// Handshake and result bundle between an issuing controller and seq_run_ctrl.
// The master issues start/abort and the configuration, the slave returns status.
interface seq_run_ctrl_if #(
    parameter int RUN_W = 4,
    parameter int WIN_W = 8,
    parameter int HIT_W = 8
);
    logic             start;
    logic             abort;
    logic [RUN_W-1:0] run_len;
    logic [WIN_W-1:0] window;
    logic             in;
    logic             busy;
    logic             done;
    logic             hit;
    logic [HIT_W-1:0] hit_count;
    logic             overflow;

    modport master (
        output start, abort, run_len, window, in,
        input  busy, done, hit, hit_count, overflow
    );

    modport slave (
        input  start, abort, run_len, window, in,
        output busy, done, hit, hit_count, overflow
    );
endinterface

// File: rtl/seq_run_ctrl.sv
// Arms on a quiet serial line, counts distinct runs of run_len ones inside a
// sample window, and reports a saturating hit count when the window closes.
//
// state | meaning
// IDLE  | waiting for start; hit_count/overflow hold the last result
// ARM   | sampling, waiting for one 0 before runs are counted
// RUN   | sampling, tracking the current run of ones
// DONE  | one-cycle done pulse, final result presented
module seq_run_ctrl #(
    parameter int RUN_W = 4,
    parameter int WIN_W = 8,
    parameter int HIT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [RUN_W-1:0] len, len_next;
    logic [RUN_W-1:0] run_cnt, run_cnt_next;
    logic [WIN_W-1:0] win_cnt, win_cnt_next;
    logic [HIT_W-1:0] hit_cnt, hit_cnt_next;
    logic             hit_q, hit_next;
    logic             ovf_q, ovf_next;
    logic             last_sample;

    assign last_sample = (win_cnt == WIN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            len     <= '0;
            run_cnt <= '0;
            win_cnt <= '0;
            hit_cnt <= '0;
            hit_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_next;
            len     <= len_next;
            run_cnt <= run_cnt_next;
            win_cnt <= win_cnt_next;
            hit_cnt <= hit_cnt_next;
            hit_q   <= hit_next;
            ovf_q   <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state;
        len_next     = len;
        run_cnt_next = run_cnt;
        win_cnt_next = win_cnt;
        hit_cnt_next = hit_cnt;
        ovf_next     = ovf_q;
        hit_next     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    hit_cnt_next = '0;
                    ovf_next     = 1'b0;
                    if (bus.window != '0) begin
                        len_next     = (bus.run_len == '0) ? RUN_W'(1) : bus.run_len;
                        win_cnt_next = bus.window;
                        run_cnt_next = '0;
                        state_next   = ARM;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            ARM, RUN: begin
                // abort wins over window expiry and discards the current sample
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    win_cnt_next = win_cnt - WIN_W'(1);
                    if (state == ARM) begin
                        if (!bus.in) begin
                            state_next = RUN;
                        end
                    end else if (bus.in) begin
                        run_cnt_next = (run_cnt == len) ? len : run_cnt + RUN_W'(1);
                        hit_next     = (run_cnt_next == len);
                        if (run_cnt == len - RUN_W'(1)) begin
                            if (hit_cnt == '1) begin
                                ovf_next = 1'b1;
                            end else begin
                                hit_cnt_next = hit_cnt + HIT_W'(1);
                            end
                        end
                    end else begin
                        run_cnt_next = '0;
                    end
                    if (last_sample) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state == ARM) || (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.hit       = hit_q;
    assign bus.hit_count = hit_cnt;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench for seq_run_ctrl: a full-width instance and a 2-bit
// hit_count instance share stimulus and are scored against a run-length model.
module tb_seq_run_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_run_ctrl_if #(.RUN_W(4), .WIN_W(8), .HIT_W(8)) bus_a ();
    seq_run_ctrl_if #(.RUN_W(4), .WIN_W(8), .HIT_W(2)) bus_b ();

    seq_run_ctrl #(.RUN_W(4), .WIN_W(8), .HIT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seq_run_ctrl #(.RUN_W(4), .WIN_W(8), .HIT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_b.start   = bus_a.start;
    assign bus_b.abort   = bus_a.abort;
    assign bus_b.run_len = bus_a.run_len;
    assign bus_b.window  = bus_a.window;
    assign bus_b.in      = bus_a.in;

    int   n_checks;
    int   n_pass;
    logic samp    [0:255];
    logic exp_hit [0:257];
    int   exp_cnt [0:257];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] v, input int n);
        for (int i = 1; i <= n; i++) samp[i] = v[n-i];
    endtask

    // Starts one observation in the current (idle) cycle and checks every cycle
    // until the block is idle again. Returns in that idle cycle with start low.
    task automatic run_obs(input int rl, input int win, input int abort_at, input bit noise);
        int len, streak, runs, last, cnt;
        bit armed;
        logic e_busy, e_done, e_hit, oa, ob;
        logic [7:0] ea;
        logic [1:0] eb;

        len = (rl == 0) ? 1 : rl;
        armed = 1'b1; streak = 0; runs = 0;
        exp_hit[1] = 1'b0; exp_cnt[1] = 0;
        for (int s = 1; s <= win; s++) begin
            if (armed) begin
                if (!samp[s]) armed = 1'b0;
                exp_hit[s+1] = 1'b0;
            end else begin
                streak = samp[s] ? streak + 1 : 0;
                if (streak == len) runs++;
                exp_hit[s+1] = (streak >= len);
            end
            exp_cnt[s+1] = runs;
        end

        bus_a.start   = 1'b1;
        bus_a.run_len = 4'(rl);
        bus_a.window  = 8'(win);
        bus_a.abort   = 1'b0;
        bus_a.in      = 1'($urandom);
        step;

        last = (abort_at != 0) ? abort_at + 1 : win + 2;
        for (int c = 1; c <= last; c++) begin
            if (abort_at != 0 && c == abort_at + 1) begin
                e_busy = 1'b0; e_done = 1'b0; e_hit = 1'b0; cnt = exp_cnt[abort_at];
            end else if (c == win + 2) begin
                e_busy = 1'b0; e_done = 1'b0; e_hit = 1'b0; cnt = exp_cnt[win+1];
            end else begin
                e_busy = (c <= win); e_done = (c == win + 1); e_hit = exp_hit[c]; cnt = exp_cnt[c];
            end
            ea = (cnt > 255) ? 8'd255 : 8'(cnt);
            eb = (cnt > 3) ? 2'd3 : 2'(cnt);
            oa = (cnt > 255);
            ob = (cnt > 3);

            n_checks++;
            if (bus_a.busy !== e_busy) $display("FAIL busy len=%0d win=%0d c=%0d got %b exp %b", rl, win, c, bus_a.busy, e_busy);
            else n_pass++;
            n_checks++;
            if (bus_a.done !== e_done) $display("FAIL done len=%0d win=%0d c=%0d got %b exp %b", rl, win, c, bus_a.done, e_done);
            else n_pass++;
            n_checks++;
            if (bus_a.hit !== e_hit) $display("FAIL hit len=%0d win=%0d c=%0d got %b exp %b", rl, win, c, bus_a.hit, e_hit);
            else n_pass++;
            n_checks++;
            if (bus_a.hit_count !== ea) $display("FAIL hit_count_a len=%0d win=%0d c=%0d got %0d exp %0d", rl, win, c, bus_a.hit_count, ea);
            else n_pass++;
            n_checks++;
            if (bus_b.hit_count !== eb) $display("FAIL hit_count_b len=%0d win=%0d c=%0d got %0d exp %0d", rl, win, c, bus_b.hit_count, eb);
            else n_pass++;
            n_checks++;
            if (bus_a.overflow !== oa) $display("FAIL overflow_a len=%0d win=%0d c=%0d got %b exp %b", rl, win, c, bus_a.overflow, oa);
            else n_pass++;
            n_checks++;
            if (bus_b.overflow !== ob) $display("FAIL overflow_b len=%0d win=%0d c=%0d got %b exp %b", rl, win, c, bus_b.overflow, ob);
            else n_pass++;

            if (c == last) begin
                bus_a.start = 1'b0;
                bus_a.abort = 1'b0;
                bus_a.in    = 1'b0;
            end else begin
                // noise: start and config changes while not idle must be ignored
                bus_a.start = noise ? 1'($urandom) : 1'b0;
                if (noise) begin
                    bus_a.run_len = 4'($urandom);
                    bus_a.window  = 8'($urandom);
                end
                bus_a.in    = (c <= win) ? samp[c] : 1'($urandom);
                bus_a.abort = (c == abort_at);
                if (noise && abort_at == 0 && c == win + 1) bus_a.abort = 1'($urandom);
                step;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_a.start = 1'b1; bus_a.window = 8'd5; bus_a.run_len = 4'd1;
        step; step;
        n_checks++;
        if (bus_a.busy !== 1'b0) $display("FAIL reset_busy_in_rst got %b exp 0", bus_a.busy);
        else n_pass++;
        rst = 1'b0; bus_a.start = 1'b0;
        step;
        n_checks++;
        if (bus_a.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus_a.busy);
        else n_pass++;
        n_checks++;
        if (bus_a.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus_a.done);
        else n_pass++;
        n_checks++;
        if (bus_a.hit !== 1'b0) $display("FAIL reset_hit got %b exp 0", bus_a.hit);
        else n_pass++;
        n_checks++;
        if (bus_a.hit_count !== 8'd0) $display("FAIL reset_hit_count got %0d exp 0", bus_a.hit_count);
        else n_pass++;
        n_checks++;
        if (bus_a.overflow !== 1'b0 || bus_b.overflow !== 1'b0)
            $display("FAIL reset_overflow got %b/%b exp 0/0", bus_a.overflow, bus_b.overflow);
        else n_pass++;
    endtask

    task automatic test_directed;
        load(64'b0111_1011_1011, 12);
        run_obs(3, 12, 0, 1'b0);
        n_checks++;
        if (bus_a.hit_count !== 8'd2) $display("FAIL directed_len3 hit_count got %0d exp 2", bus_a.hit_count);
        else n_pass++;

        load(64'b111011, 6);
        run_obs(2, 6, 0, 1'b0);
        n_checks++;
        if (bus_a.hit_count !== 8'd1) $display("FAIL directed_len2 hit_count got %0d exp 1", bus_a.hit_count);
        else n_pass++;

        load(64'b0101, 4);
        run_obs(0, 4, 0, 1'b0);
        n_checks++;
        if (bus_a.hit_count !== 8'd2) $display("FAIL directed_len0 hit_count got %0d exp 2", bus_a.hit_count);
        else n_pass++;

        run_obs(3, 0, 0, 1'b0);
    endtask

    task automatic test_saturation;
        for (int s = 1; s <= 20; s++) samp[s] = (s % 2 == 0);
        run_obs(1, 20, 0, 1'b0);
        n_checks++;
        if (bus_b.hit_count !== 2'd3 || bus_b.overflow !== 1'b1)
            $display("FAIL saturation_b got %0d/%b exp 3/1", bus_b.hit_count, bus_b.overflow);
        else n_pass++;
        n_checks++;
        if (bus_a.hit_count !== 8'd10) $display("FAIL saturation_a got %0d exp 10", bus_a.hit_count);
        else n_pass++;
        run_obs(2, 0, 0, 1'b0);
        n_checks++;
        if (bus_b.hit_count !== 2'd0 || bus_b.overflow !== 1'b0)
            $display("FAIL saturation_clear got %0d/%b exp 0/0", bus_b.hit_count, bus_b.overflow);
        else n_pass++;
    endtask

    task automatic test_abort;
        load(64'b0110_1111_11, 10);
        run_obs(2, 10, 5, 1'b1);
        n_checks++;
        if (bus_a.hit_count !== 8'd1) $display("FAIL abort_retain got %0d exp 1", bus_a.hit_count);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            step;
            n_checks++;
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0)
                $display("FAIL abort_quiet cycle=%0d got done=%b busy=%b exp 0/0", i, bus_a.done, bus_a.busy);
            else n_pass++;
        end
    endtask

    task automatic test_rst_mid;
        bus_a.start = 1'b1; bus_a.run_len = 4'd1; bus_a.window = 8'd10; bus_a.in = 1'b0;
        step;
        bus_a.start = 1'b0; bus_a.in = 1'b0;
        step;
        bus_a.in = 1'b1;
        step;
        n_checks++;
        if (bus_a.hit_count !== 8'd1 || bus_a.busy !== 1'b1)
            $display("FAIL rst_mid_pre got count=%0d busy=%b exp 1/1", bus_a.hit_count, bus_a.busy);
        else n_pass++;
        rst = 1'b1;
        step;
        n_checks++;
        if ({bus_a.busy, bus_a.done, bus_a.hit, bus_a.overflow, bus_b.overflow} !== 5'b0 ||
            bus_a.hit_count !== 8'd0 || bus_b.hit_count !== 2'd0)
            $display("FAIL rst_mid got busy=%b done=%b hit=%b count=%0d exp all 0",
                     bus_a.busy, bus_a.done, bus_a.hit, bus_a.hit_count);
        else n_pass++;
        rst = 1'b0; bus_a.in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step;
            n_checks++;
            if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0)
                $display("FAIL rst_mid_quiet cycle=%0d got done=%b busy=%b exp 0/0", i, bus_a.done, bus_a.busy);
            else n_pass++;
        end
    endtask

    task automatic test_random_back_to_back;
        int rl, win, ab;
        for (int k = 0; k < 40; k++) begin
            rl  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            win = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            for (int s = 1; s <= win; s++) samp[s] = ($urandom_range(0, 9) < 7);
            ab  = (win > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, win) : 0;
            run_obs(rl, win, ab, 1'b1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.run_len = '0;
        bus_a.window = '0;  bus_a.in = 1'b0;
        test_reset();
        test_directed();
        test_saturation();
        test_abort();
        test_rst_mid();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_run_ctrl.md
Name: seq_run_ctrl

Overview:
Controller that arms, times and scores a run-of-ones sequence detector on a serial input `in`. Software or an upstream FSM issues `start` with a programmable run length and observation window. The block then:
- waits for the line to go quiet (one 0 sample), so a run already in progress is not counted;
- detects runs of `run_len` consecutive 1s, flagging each cycle a match is held;
- counts distinct matching runs, and reports `done` with a saturating hit count at the end of the window.

Parameters:
RUN_W, 4, width of run_len and the internal run counter
WIN_W, 8, width of window and the internal window counter
HIT_W, 8, width of hit_count

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin an observation; ignored unless idle
abort  input  1  terminate an active observation, no done pulse
run_len  input  RUN_W  required run of 1s; sampled on accepted start; 0 treated as 1
window  input  WIN_W  number of samples to observe; sampled on accepted start
in  input  1  serial data under observation
busy  output  1  high in ARM and RUN
done  output  1  one-cycle pulse at end of window
hit  output  1  registered match flag
hit_count  output  HIT_W  number of distinct matching runs in current/last window
overflow  output  1  sticky, hit_count saturated

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high. No asynchronous logic.
- Reset values:
  - state = IDLE;
  - busy = 0, done = 0, hit = 0, overflow = 0;
  - hit_count = 0;
  - internal run_cnt = 0, win_cnt = 0.
- States: IDLE, ARM, RUN, DONE (2-bit encoding).
- IDLE:
  - busy = 0, hit = 0.
  - start = 1 with window != 0: latch len = max(run_len, 1) and win_cnt = window; clear hit_count, overflow and run_cnt; go to ARM.
  - start = 1 with window == 0: clear hit_count and overflow; go directly to DONE.
- Sample timing: with start accepted in cycle 0, busy = 1 from cycle 1. `in` is sampled in cycles 1..window, exactly `window` samples across ARM and RUN. win_cnt decrements on each sample.
- ARM:
  - in = 1: ignored, run_cnt stays 0.
  - in = 0: go to RUN.
  - Window expiry in ARM goes to DONE with hit_count = 0.
- RUN:
  - in = 1: run_cnt = min(run_cnt + 1, len).
  - in = 0: run_cnt = 0.
  - hit (registered) = 1 in the cycle after any sample where the updated run_cnt == len. hit stays high for every further consecutive 1 (overlapping match, Moore-style).
  - hit_count increments once per run, only when run_cnt transitions from len-1 to len. It becomes visible one cycle after the completing sample.
- Window end: the sample with win_cnt == 1 is the last one; the next state is DONE.
- DONE (one cycle):
  - done = 1, busy = 0.
  - hit reflects the last sample.
  - hit_count holds its final value, including a completion on the last sample.
  - Next state is IDLE.
- Saturation: an increment at hit_count = all-ones holds all-ones and sets overflow. overflow is sticky until the next accepted start or rst.
- hit_count and overflow hold in IDLE until the next accepted start.
- start while busy or in DONE: ignored, no queuing.
- abort while busy:
  - next state IDLE, no done pulse;
  - hit = 0;
  - hit_count and overflow retain their partial values.
  - abort has priority over window expiry in the same cycle.
  - abort in IDLE or DONE has no effect.
- rst mid-observation: all state and outputs return to reset values in the next cycle; no done pulse.
- run_len and window changes after start are ignored until the next start.

Test Plan:
- rst held 2 cycles, then released -> busy=0, done=0, hit=0, hit_count=0, overflow=0; start=1 with rst=1 is not accepted.
- run_len=3, window=12, in per cycle 1..12 = 0,1,1,1,1,0,1,1,1,0,1,1 -> hit high cycles 5,6 and 10; hit_count=2; done at cycle 13.
- run_len=2, window=6, in = 1,1,1,0,1,1 -> cycles 1-3 ignored in ARM; RUN entered at cycle 4; hit at cycle 7 coincident with done; hit_count=1.
- run_len=0 (treated as 1), window=4, in = 0,1,0,1 -> hit_count=2; run_len=3, window=0 -> done on cycle after start, hit_count=0, busy never high.
- HIT_W=2, run_len=1, window=20, in alternating 0,1 -> hit_count saturates at 3, overflow=1 at done; the next start clears both.
- abort at cycle 5 of window=10 after one hit -> IDLE, no done, hit_count=1 retained; start during busy ignored; rst at cycle 3 -> all outputs 0 the following cycle.
